// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } hz_state_e;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // True when a writing stage targets src; x0 never counts as a producer.
    function automatic logic reg_hit(input logic [4:0] rd, input logic we, input logic [4:0] src);
        return we && (rd != 5'd0) && (rd == src);
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline-side bundle of the hazard controller: stage register ids in,
// enables / flushes / forward selects / status out.
interface pipeline_hazard_ctrl_if #(parameter int CNT_W = 16);
    logic [4:0]       Rs1_D, Rs2_D, Rs1_E, Rs2_E, Rd_E, Rd_M, Rd_W;
    logic             regWrite_E, MemToReg_E, branch_taken_E;
    logic             regWrite_M, regWrite_W, mem_req_M, mem_ready;
    logic             Enable_F, Enable_D, Enable_E, Enable_M, Enable_W;
    logic             Flush_D, Flush_E;
    logic [1:0]       ForwardA_E, ForwardB_E;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_count;

    modport master (
        output Rs1_D, Rs2_D, Rs1_E, Rs2_E, Rd_E, Rd_M, Rd_W,
        output regWrite_E, MemToReg_E, branch_taken_E,
        output regWrite_M, regWrite_W, mem_req_M, mem_ready,
        input  Enable_F, Enable_D, Enable_E, Enable_M, Enable_W,
        input  Flush_D, Flush_E, ForwardA_E, ForwardB_E,
        input  mem_timeout, stall_count
    );

    modport slave (
        input  Rs1_D, Rs2_D, Rs1_E, Rs2_E, Rd_E, Rd_M, Rd_W,
        input  regWrite_E, MemToReg_E, branch_taken_E,
        input  regWrite_M, regWrite_W, mem_req_M, mem_ready,
        output Enable_F, Enable_D, Enable_E, Enable_M, Enable_W,
        output Flush_D, Flush_E, ForwardA_E, ForwardB_E,
        output mem_timeout, stall_count
    );
endinterface

// File: rtl/pipeline_hazard_ctrl_forward_unit.sv
// One EX operand's forwarding comparator: MEM result beats WB result.
module forward_unit
    import hazard_pkg::*;
(
    input  logic       active,
    input  logic [4:0] src,
    input  logic [4:0] rd_m,
    input  logic       we_m,
    input  logic [4:0] rd_w,
    input  logic       we_w,
    output logic [1:0] sel
);

    // Pick the youngest in-flight producer of src, or the register file.
    always_comb begin
        sel = FWD_RF;
        if (!active) begin
            sel = FWD_RF;
        end else if (reg_hit(rd_m, we_m, src)) begin
            sel = FWD_MEM;
        end else if (reg_hit(rd_w, we_w, src)) begin
            sel = FWD_WB;
        end else begin
            sel = FWD_RF;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall / flush / forward controller for the five-stage pipeline, with a
// memory-wait FSM (timeout to a sticky error) and a saturating stall counter.
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    pipeline_hazard_ctrl_if.slave hz
);

    hz_state_e        state_q, state_d;
    logic [7:0]       wait_cnt_q, wait_cnt_d;
    logic             mem_timeout_q, mem_timeout_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic [4:0] en_s;          // {F, D, E, M, W}
    logic       flush_d_s, flush_e_s;
    logic       resolve_s;     // branch / load-use rules apply this cycle
    logic       load_use_s;
    logic       fwd_active_s;

    assign fwd_active_s = ~rst;

    // Load in EX feeding the instruction in ID.
    always_comb begin
        load_use_s = hz.MemToReg_E &&
                     (reg_hit(hz.Rd_E, hz.regWrite_E, hz.Rs1_D) ||
                      reg_hit(hz.Rd_E, hz.regWrite_E, hz.Rs2_D));
    end

    // FSM next state and wait counter; decides when hazard rules are applied.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        resolve_s  = 1'b0;
        if (rst) begin
            state_d    = RUN;
            wait_cnt_d = 8'd0;
        end else begin
            case (state_q)
                RUN: begin
                    if (hz.mem_req_M && !hz.mem_ready) begin
                        state_d    = MEM_WAIT;
                        wait_cnt_d = 8'd1;
                    end else begin
                        resolve_s = 1'b1;
                    end
                end
                MEM_WAIT: begin
                    if (hz.mem_ready) begin
                        resolve_s  = 1'b1;
                        state_d    = RUN;
                        wait_cnt_d = 8'd0;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 8'd1;
                        if (wait_cnt_q == 8'(MEM_TIMEOUT)) begin
                            state_d = ERROR;
                        end else begin
                            state_d = MEM_WAIT;
                        end
                    end
                end
                ERROR: begin
                    state_d = ERROR;
                end
                default: begin
                    state_d    = RUN;
                    wait_cnt_d = 8'd0;
                end
            endcase
        end
    end

    // Priority of branch flush over load-use bubble; frozen otherwise.
    always_comb begin
        en_s      = 5'b00000;
        flush_d_s = 1'b0;
        flush_e_s = 1'b0;
        if (resolve_s) begin
            if (hz.branch_taken_E) begin
                en_s      = 5'b11111;
                flush_d_s = 1'b1;
                flush_e_s = 1'b1;
            end else if (load_use_s) begin
                en_s      = 5'b00111;
                flush_e_s = 1'b1;
            end else begin
                en_s = 5'b11111;
            end
        end else begin
            en_s = 5'b00000;
        end
    end

    // Sticky error flag and saturating count of cycles with the PC held.
    always_comb begin
        mem_timeout_d = mem_timeout_q || (state_q == ERROR);
        if (!en_s[4] && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= RUN;
            wait_cnt_q    <= 8'd0;
            mem_timeout_q <= 1'b0;
            stall_cnt_q   <= {CNT_W{1'b0}};
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
            stall_cnt_q   <= stall_cnt_d;
        end
    end

    forward_unit u_fwd_a (
        .active (fwd_active_s),
        .src    (hz.Rs1_E),
        .rd_m   (hz.Rd_M),
        .we_m   (hz.regWrite_M),
        .rd_w   (hz.Rd_W),
        .we_w   (hz.regWrite_W),
        .sel    (hz.ForwardA_E)
    );

    forward_unit u_fwd_b (
        .active (fwd_active_s),
        .src    (hz.Rs2_E),
        .rd_m   (hz.Rd_M),
        .we_m   (hz.regWrite_M),
        .rd_w   (hz.Rd_W),
        .we_w   (hz.regWrite_W),
        .sel    (hz.ForwardB_E)
    );

    assign hz.Enable_F    = en_s[4];
    assign hz.Enable_D    = en_s[3];
    assign hz.Enable_E    = en_s[2];
    assign hz.Enable_M    = en_s[1];
    assign hz.Enable_W    = en_s[0];
    assign hz.Flush_D     = flush_d_s;
    assign hz.Flush_E     = flush_e_s;
    assign hz.mem_timeout = mem_timeout_q;
    assign hz.stall_count = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios with literal expectations,
// then random traffic checked every cycle against a behavioural model.
module tb_pipeline_hazard_ctrl;
    import hazard_pkg::*;

    localparam int TMO = 4;
    localparam int CW  = 4;
    localparam int SAT = 15;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if #(.CNT_W(CW)) hz();

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [4:0] en_vec();
        return {hz.Enable_F, hz.Enable_D, hz.Enable_E, hz.Enable_M, hz.Enable_W};
    endfunction

    // ---------------- behavioural model ----------------
    bit m_waiting = 1'b0;   // a memory access is outstanding past its first cycle
    bit m_error   = 1'b0;   // controller has given up on memory
    bit m_to      = 1'b0;   // expected mem_timeout flag
    int m_wait_len = 0;     // completed waiting cycles of the outstanding access
    int m_stalls   = 0;     // unsaturated count of PC-held cycles

    function automatic logic [1:0] exp_fwd(input logic [4:0] x);
        if (hz.regWrite_M && hz.Rd_M != 5'd0 && hz.Rd_M == x) return 2'b10;
        if (hz.regWrite_W && hz.Rd_W != 5'd0 && hz.Rd_W == x) return 2'b01;
        return 2'b00;
    endfunction

    // Compare DUT to the model mid-cycle, then advance the model to the next edge.
    always @(negedge clk) begin
        logic [4:0] e_en;
        logic [1:0] e_fl;
        logic       frozen, lu;
        int         sat;
        lu = hz.MemToReg_E && hz.regWrite_E && hz.Rd_E != 5'd0 &&
             (hz.Rd_E == hz.Rs1_D || hz.Rd_E == hz.Rs2_D);
        frozen = m_error || (m_waiting && !hz.mem_ready) ||
                 (!m_waiting && hz.mem_req_M && !hz.mem_ready);
        if (rst || frozen) begin
            e_en = 5'b00000; e_fl = 2'b00;
        end else if (hz.branch_taken_E) begin
            e_en = 5'b11111; e_fl = 2'b11;
        end else if (lu) begin
            e_en = 5'b00111; e_fl = 2'b01;
        end else begin
            e_en = 5'b11111; e_fl = 2'b00;
        end
        sat = (m_stalls > SAT) ? SAT : m_stalls;
        chk("model_enables", en_vec(), e_en);
        chk("model_flushes", {hz.Flush_D, hz.Flush_E}, e_fl);
        chk("model_fwdA", hz.ForwardA_E, rst ? 2'b00 : exp_fwd(hz.Rs1_E));
        chk("model_fwdB", hz.ForwardB_E, rst ? 2'b00 : exp_fwd(hz.Rs2_E));
        chk("model_stall_count", hz.stall_count, sat);
        chk("model_mem_timeout", hz.mem_timeout, m_to);
        if (rst) begin
            m_waiting = 1'b0; m_error = 1'b0; m_to = 1'b0;
            m_wait_len = 0; m_stalls = 0;
        end else begin
            if (!e_en[4]) m_stalls++;
            m_to = m_to || m_error;
            if (m_error) begin
                m_error = 1'b1;
            end else if (m_waiting) begin
                if (hz.mem_ready) begin
                    m_waiting = 1'b0;
                end else begin
                    m_wait_len++;
                    if (m_wait_len == TMO) begin
                        m_error = 1'b1; m_waiting = 1'b0;
                    end
                end
            end else if (hz.mem_req_M && !hz.mem_ready) begin
                m_waiting = 1'b1; m_wait_len = 0;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic adv(); @(posedge clk); #1; endtask
    task automatic smp(); @(negedge clk); endtask

    task automatic idle();
        hz.Rs1_D = 5'd0; hz.Rs2_D = 5'd0; hz.Rs1_E = 5'd0; hz.Rs2_E = 5'd0;
        hz.Rd_E = 5'd0; hz.Rd_M = 5'd0; hz.Rd_W = 5'd0;
        hz.regWrite_E = 1'b0; hz.MemToReg_E = 1'b0; hz.branch_taken_E = 1'b0;
        hz.regWrite_M = 1'b0; hz.regWrite_W = 1'b0;
        hz.mem_req_M = 1'b0; hz.mem_ready = 1'b0;
    endtask

    task automatic set_load_use();
        hz.MemToReg_E = 1'b1; hz.regWrite_E = 1'b1; hz.Rd_E = 5'd5; hz.Rs1_D = 5'd5;
    endtask

    initial begin
        int ready_pct;
        rst = 1'b1;
        idle();
        // Forward hit presented during reset must stay 00.
        hz.regWrite_M = 1'b1; hz.Rd_M = 5'd3; hz.Rs1_E = 5'd3;
        smp();
        chk("rst_enables", en_vec(), 5'b00000);
        chk("rst_flushes", {hz.Flush_D, hz.Flush_E}, 2'b00);
        chk("rst_fwdA", hz.ForwardA_E, 2'b00);
        adv(); adv();
        rst = 1'b0; idle();
        smp();
        chk("rst_stall_count", hz.stall_count, 0);
        chk("rst_mem_timeout", hz.mem_timeout, 0);
        chk("idle_enables", en_vec(), 5'b11111);

        // Load-use: one bubble.
        adv(); set_load_use();
        smp();
        chk("lu_enables", en_vec(), 5'b00111);
        chk("lu_flushes", {hz.Flush_D, hz.Flush_E}, 2'b01);
        adv(); idle();
        smp();
        chk("lu_after_enables", en_vec(), 5'b11111);
        chk("lu_stall_count", hz.stall_count, 1);

        // Forwarding priority and x0.
        adv(); hz.regWrite_M = 1'b1; hz.Rd_M = 5'd7; hz.regWrite_W = 1'b1; hz.Rd_W = 5'd7;
        hz.Rs1_E = 5'd7; hz.Rs2_E = 5'd0;
        smp();
        chk("fwd_mem_over_wb", hz.ForwardA_E, 2'b10);
        chk("fwd_x0", hz.ForwardB_E, 2'b00);
        adv(); hz.Rd_M = 5'd0; hz.Rd_W = 5'd9; hz.Rs1_E = 5'd0; hz.Rs2_E = 5'd9;
        smp();
        chk("fwd_rdm_x0", hz.ForwardA_E, 2'b00);
        chk("fwd_wb", hz.ForwardB_E, 2'b01);

        // Taken branch beats load-use.
        adv(); idle(); set_load_use(); hz.branch_taken_E = 1'b1;
        smp();
        chk("br_enables", en_vec(), 5'b11111);
        chk("br_flushes", {hz.Flush_D, hz.Flush_E}, 2'b11);

        // Three-cycle memory access.
        adv(); idle(); rst = 1'b1;
        adv(); rst = 1'b0; hz.mem_req_M = 1'b1; hz.mem_ready = 1'b0;
        smp(); chk("mem3_c0_enables", en_vec(), 5'b00000);
        adv(); smp(); chk("mem3_c1_enables", en_vec(), 5'b00000);
        adv(); hz.mem_ready = 1'b1;
        smp(); chk("mem3_release_enables", en_vec(), 5'b11111);
        adv(); idle();
        smp();
        chk("mem3_stall_count", hz.stall_count, 2);
        chk("mem3_run_enables", en_vec(), 5'b11111);

        // Timeout into the sticky error.
        adv(); rst = 1'b1;
        adv(); rst = 1'b0; hz.mem_req_M = 1'b1; hz.mem_ready = 1'b0;
        repeat (5) adv();
        smp();
        chk("tmo_first_err_flag", hz.mem_timeout, 0);
        chk("tmo_first_err_enables", en_vec(), 5'b00000);
        adv(); hz.mem_req_M = 1'b0; hz.mem_ready = 1'b1;
        smp();
        chk("tmo_flag", hz.mem_timeout, 1);
        chk("tmo_err_enables", en_vec(), 5'b00000);
        adv(); adv(); smp();
        chk("tmo_flag_sticky", hz.mem_timeout, 1);
        adv(); rst = 1'b1;
        adv(); rst = 1'b0; idle();
        smp();
        chk("tmo_cleared_flag", hz.mem_timeout, 0);
        chk("tmo_cleared_enables", en_vec(), 5'b11111);

        // Reset in the middle of a memory wait.
        adv(); hz.mem_req_M = 1'b1; hz.mem_ready = 1'b0;
        adv(); adv(); rst = 1'b1;
        adv(); rst = 1'b0; idle();
        smp();
        chk("rstwait_enables", en_vec(), 5'b11111);
        chk("rstwait_stall_count", hz.stall_count, 0);

        // Random traffic, model-checked every cycle.
        ready_pct = 50;
        for (int i = 0; i < 3000; i++) begin
            adv();
            if (i % 200 == 0) begin
                case ($urandom_range(0, 2))
                    0: ready_pct = 10;
                    1: ready_pct = 50;
                    default: ready_pct = 90;
                endcase
            end
            rst = ($urandom_range(0, 99) == 0);
            hz.Rs1_D = 5'($urandom_range(0, 7)); hz.Rs2_D = 5'($urandom_range(0, 7));
            hz.Rs1_E = 5'($urandom_range(0, 7)); hz.Rs2_E = 5'($urandom_range(0, 7));
            hz.Rd_E = 5'($urandom_range(0, 7));  hz.Rd_M = 5'($urandom_range(0, 7));
            hz.Rd_W = 5'($urandom_range(0, 7));
            hz.regWrite_E = 1'($urandom_range(0, 1)); hz.MemToReg_E = 1'($urandom_range(0, 1));
            hz.branch_taken_E = ($urandom_range(0, 9) == 0);
            hz.regWrite_M = 1'($urandom_range(0, 1)); hz.regWrite_W = 1'($urandom_range(0, 1));
            hz.mem_req_M = ($urandom_range(0, 99) < 30);
            hz.mem_ready = ($urandom_range(0, 99) < ready_pct);
        end
        adv(); rst = 1'b0; idle();
        smp();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

- Central stall/flush/forward controller for the five-stage pipeline.
- Drives the `Enable` input of every pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC, plus bubble-insert flushes for IF/ID and ID/EX.
- Drives EX-stage operand forwarding selects.
- Sequences multi-cycle data-memory accesses through a small FSM with timeout, and counts stall cycles for performance monitoring.

## Interface
Parameters:
- `MEM_TIMEOUT`, default 15: number of MEM_WAIT cycles before declaring a memory error (range 1–255).
- `CNT_W`, default 16: width of the stall counter.

Ports:
- `clk`  in  1  single clock; all flops on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `Rs1_D`, `Rs2_D`  in  5 each  source registers of the instruction in ID.
- `Rs1_E`, `Rs2_E`  in  5 each  source registers of the instruction in EX.
- `Rd_E`  in  5  destination of the instruction in EX.
- `regWrite_E`, `MemToReg_E`  in  1 each  EX instruction writes a register / is a load.
- `branch_taken_E`  in  1  EX resolved a taken branch, jal or jalr (PC redirect).
- `Rd_M`, `regWrite_M`  in  5 / 1  MEM-stage destination and write enable.
- `Rd_W`, `regWrite_W`  in  5 / 1  WB-stage destination and write enable.
- `mem_req_M`  in  1  MEM instruction is a load or store.
- `mem_ready`  in  1  data memory completes the access this cycle.
- `Enable_F`, `Enable_D`, `Enable_E`, `Enable_M`, `Enable_W`  out  1 each  enables for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- `Flush_D`, `Flush_E`  out  1 each  synchronously clear IF/ID and ID/EX to a bubble on the next edge.
- `ForwardA_E`, `ForwardB_E`  out  2 each  operand select: 00 regfile, 01 WB result, 10 MEM `alu_OUT`.
- `mem_timeout`  out  1  sticky error flag.
- `stall_count`  out  `CNT_W`  saturating count of cycles with `Enable_F`=0.

## Operation
- **FSM states:** RUN, MEM_WAIT, ERROR. Reset state is RUN.
- **RUN, memory stall:** if `mem_req_M` && !`mem_ready`:
  - all five `Enable_*`=0, both `Flush_*`=0;
  - next state MEM_WAIT, wait counter loads 1.
- **RUN, no memory stall:** apply priority, highest first:
  1. `branch_taken_E`: all enables 1; `Flush_D`=1, `Flush_E`=1. Branch overrides load-use because the ID instruction is squashed.
  2. Load-use: `MemToReg_E` && `regWrite_E` && `Rd_E`≠0 && (`Rd_E`==`Rs1_D` || `Rd_E`==`Rs2_D`). Then `Enable_F`=`Enable_D`=0, `Flush_E`=1, `Enable_E`=`Enable_M`=`Enable_W`=1.
  3. Otherwise all enables 1, flushes 0.
- **MEM_WAIT:** all enables 0, flushes 0.
  - On `mem_ready`=1: this cycle is the completion cycle. Outputs are those of RUN evaluated with no memory stall (the branch and load-use rules apply). Next state RUN.
  - Else the wait counter increments. If the counter == `MEM_TIMEOUT`: next state ERROR.
- **ERROR:** all enables 0, flushes 0, `mem_timeout`=1. Exit only via `rst`.
- **Branch during a memory stall:** not acted on. ID/EX is frozen, so `branch_taken_E` persists and is handled in the release cycle.
- **Forwarding (combinational, per operand X ∈ {Rs1_E, Rs2_E}):**
  - 10 if `regWrite_M` && `Rd_M`≠0 && `Rd_M`==X;
  - else 01 if `regWrite_W` && `Rd_W`≠0 && `Rd_W`==X;
  - else 00.
  - MEM wins over WB. Register x0 is never forwarded.
  - Forwarding is independent of the FSM state.
- **`stall_count`:** +1 on every non-reset cycle with `Enable_F`=0; saturates at all-ones.

## Timing
- Enables and flushes are combinational from the current state and inputs, and take effect at the same edge.
- Flush takes effect at the next rising edge. Flush and Enable=1 together mean "load a bubble".
- Load-use costs exactly 1 cycle.
- A memory access of N cycles (`mem_ready` arriving N-1 cycles after the request is presented) freezes the pipeline for N-1 cycles. A zero-wait access (`mem_ready` in the same cycle) has no stall.
- ERROR is entered at the edge ending the `MEM_TIMEOUT`-th MEM_WAIT cycle. `mem_timeout` rises one cycle after that edge.
- **While `rst`=1:**
  - all `Enable_*`=0, all `Flush_*`=0, `Forward*`=00;
  - at the edge: state RUN, wait counter 0, `mem_timeout`=0, `stall_count`=0.
- **Reset mid-MEM_WAIT or in ERROR:** returns to RUN at the next edge with no residual stall.

## Structure
- Package `hazard_pkg`:
  - `hz_state_e` enum (RUN, MEM_WAIT, ERROR);
  - forward-select constants FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
- Sub-module `forward_unit`: one operand's comparator; instantiated twice (A, B).
- FSM, wait counter, stall counter and priority logic live in `pipeline_hazard_ctrl`.

## Test plan
- **Load-use:** lw x5 in EX (`MemToReg_E`=1, `Rd_E`=5), add with `Rs1_D`=5 → exactly one cycle with `Enable_F`=`Enable_D`=0, `Flush_E`=1; `stall_count` 0→1.
- **Forward priority:** `Rd_M`=`Rd_W`=7, both write, `Rs1_E`=7 → `ForwardA_E`=10. With `Rd_M`=0 and `Rs2_E`=0 → `ForwardB_E`=00.
- **Taken branch and load-use together:** `branch_taken_E`=1 with load-use conditions true → `Flush_D`=`Flush_E`=1, all enables 1.
- **3-cycle memory access:** `mem_req_M`=1, `mem_ready` low for 2 cycles → 2 cycles all enables 0; release cycle all enables 1; state back to RUN; `stall_count`=2.
- **Timeout:** `MEM_TIMEOUT`=4, `mem_ready` held 0 → ERROR after 4 MEM_WAIT cycles; `mem_timeout`=1 and stays 1; `rst` clears it and all enables return to 1.
- **Reset mid-stall:** `rst` pulsed in MEM_WAIT → next cycle RUN, `stall_count`=0, enables 1 when `mem_req_M`=0.
